uart_bit_timer: RTL and testbench
=================================

Name: uart_bit_timer

Overview:
Parametrised frame timer for the UART. It combines a baud prescaler, an oversample counter and a frame bit-index counter into one block. It replaces the fixed 4-bit bit counter and serves both the TX serializer (end-of-bit strobes) and the RX deserializer (mid-bit sample strobes), selected per frame by a mode input.

Parameters:
DIV_W, 16, width of the baud divisor (system clocks per oversample tick)
OSR, 16, oversample ticks per bit; even, >= 4
MAX_BITS, 12, maximum frame length in bits (start + data + parity + stop)
BIT_W, $clog2(MAX_BITS), width of the bit index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_clear  in  1  synchronous abort; returns the block to idle
i_ena  in  1  count enable; low freezes all counters
i_start  in  1  start a frame; accepted only when idle or in the done cycle
i_mode  in  1  uart_mode_e: TX_MODE=0 gives end-of-bit strobes, RX_MODE=1 gives mid-bit strobes
i_divisor  in  DIV_W  clocks per oversample tick; sampled at start
i_num_bits  in  BIT_W+1  frame length; sampled at start
o_busy  out  1  frame in progress
o_tick  out  1  oversample tick pulse
o_bit_strobe  out  1  bit event pulse
o_bit_idx  out  BIT_W  current bit index, 0 = start bit
o_done  out  1  one-cycle pulse on the last bit strobe

Behaviour:
- Reset (rst low, async): every internal register is 0.
  - o_busy, o_tick, o_bit_strobe and o_done are 0; o_bit_idx is 0.
  - Reset asserted mid-frame aborts the frame; no o_done is produced.
- Idle (IDLE): counters are held at 0 and no pulses are produced.
- Start: i_start high at a clock edge while idle (with i_clear low) latches mode, divisor and num_bits.
  - That cycle is cycle 0; the block is in RUN with o_busy=1 from cycle 1.
  - i_start is accepted even if i_ena is low.
- Input sanitising:
  - i_divisor==0 is treated as 1.
  - i_num_bits==0 is treated as 1; values above MAX_BITS are clamped to MAX_BITS.
- Prescaler: pre_cnt counts 0..D-1.
  - o_tick = busy & i_ena & (pre_cnt==D-1), combinational from registered state.
  - pre_cnt wraps to 0 on a tick, so tick k occurs at cycle k*D.
- Oversample counter: os_cnt counts 0..OSR-1, advancing on o_tick and wrapping to 0.
  - On the wrap, bit_idx increments.
- Strobe:
  - TX mode: o_bit_strobe = o_tick & (os_cnt==OSR-1).
  - RX mode: o_bit_strobe = o_tick & (os_cnt==OSR/2-1).
  - o_bit_idx equals the index of the bit being strobed during the strobe.
- Done: o_done = o_bit_strobe & (bit_idx==num_bits_r-1).
  - The next cycle returns to IDLE (o_busy=0, counters 0) unless a restart occurs.
  - In RX mode the remaining half stop bit is not timed; the frame ends at the stop-bit sample.
- Back-to-back frames: i_start in the o_done cycle reloads mode, divisor and num_bits, and zeroes the counters.
  - o_busy stays 1 and the new frame's cycle 0 is the done cycle.
- i_start while busy outside the done cycle is ignored, with no side effect.
- i_ena low: pre_cnt, os_cnt and bit_idx hold, and no tick, strobe or done is produced.
  - All event times shift by the number of disabled cycles.
- i_clear: synchronous, with priority over i_start and i_ena.
  - Next cycle: IDLE, counters 0, o_busy=0.
  - No o_done, even if the clear coincides with the last strobe; o_done is masked by i_clear.
- Widths: pre_cnt is DIV_W bits, os_cnt is $clog2(OSR) bits, bit_idx is BIT_W bits. No overflow is possible after clamping.

Decomposition:
- pkg_uart adds:
  - typedef uart_mode_e {TX_MODE, RX_MODE};
  - typedef div_t logic [DIV_W-1:0];
  - typedef bit_idx_t logic [BIT_W-1:0];
  - constants UART_OSR = 16 and UART_MAX_BITS = 12.
  - The existing count_t is kept for legacy users.
- Sub-module uart_tick_gen contains the prescaler only.
  - Ports: clk, rst, i_clear, i_ena, i_run, i_divisor, o_tick.
  - Instantiated once. os_cnt, bit_idx and the FSM stay in uart_bit_timer.

Test Plan:
- TX, D=3, OSR=16, num_bits=10, i_ena=1, start at cycle 0 -> ticks at 3,6,9…; strobes at 48,96,…,480 with idx 0..9; o_done at 480; o_busy=0 at 481.
- RX, same settings -> strobes at 24+48k (24..456) with idx 0..9; o_done at 456.
- Divisor 0, TX, num_bits=1 -> tick every cycle from cycle 1; single strobe + o_done at cycle 16; num_bits=15 clamps (done at idx 11).
- i_ena low for cycles 10..19 in the first TX case -> every event delayed 10 cycles (done at 490); i_start at cycle 200 ignored.
- i_clear at cycle 100 -> o_busy=0 at 101, no further strobes, no o_done; async rst low at cycle 300 of a second frame -> all outputs 0 immediately, idle after release.
- i_start asserted in done cycle 480 with RX mode, D=1 -> o_busy continuous, first RX strobe at cycle 488.

Source files
------------

// File: rtl/pkg_uart.sv
// Shared UART types and constants: line mode, divisor/bit-index types and default frame geometry.
// count_t is the old fixed 4-bit bit counter type, still used by older blocks.
package pkg_uart;
  localparam int UART_OSR      = 16;
  localparam int UART_MAX_BITS = 12;
  localparam int UART_DIV_W    = 16;
  localparam int UART_BIT_W    = $clog2(UART_MAX_BITS);

  typedef enum logic {TX_MODE = 1'b0, RX_MODE = 1'b1} uart_mode_e;
  typedef logic [UART_DIV_W-1:0] div_t;
  typedef logic [UART_BIT_W-1:0] bit_idx_t;
  typedef logic [3:0]            count_t;
endpackage

// File: rtl/uart_tick_gen.sv
// Baud prescaler: emits o_tick every i_divisor enabled cycles while i_run is high (combinational from pre_cnt_q).
// Stalls on i_ena low; i_divisor must be nonzero.
module uart_tick_gen
  import pkg_uart::*;
#(
  parameter int DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_ena,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_divisor,
  output logic             o_tick
);

  logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;

  always_comb begin
    o_tick    = i_run & i_ena & (pre_cnt_q == (i_divisor - DIV_W'(1)));
    pre_cnt_d = pre_cnt_q;
    if (i_clear || !i_run) begin
      pre_cnt_d = '0;
    end else if (o_tick) begin
      pre_cnt_d = '0;
    end else if (i_ena) begin
      pre_cnt_d = pre_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pre_cnt_q <= '0;
    else      pre_cnt_q <= pre_cnt_d;
  end

endmodule

// File: rtl/uart_bit_timer.sv
// UART frame timer: prescaler + oversample counter + bit index; end-of-bit (TX) or mid-bit (RX) strobes.
// Busy from the cycle after start; i_ena low freezes all counters and suppresses every pulse.
module uart_bit_timer
  import pkg_uart::*;
#(
  parameter int DIV_W    = UART_DIV_W,
  parameter int OSR      = UART_OSR,
  parameter int MAX_BITS = UART_MAX_BITS,
  parameter int BIT_W    = $clog2(MAX_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_ena,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [DIV_W-1:0] i_divisor,
  input  logic [BIT_W:0]   i_num_bits,
  output logic             o_busy,
  output logic             o_tick,
  output logic             o_bit_strobe,
  output logic [BIT_W-1:0] o_bit_idx,
  output logic             o_done
);

  localparam int OS_W = $clog2(OSR);
  localparam int NB_W = BIT_W + 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OSR / 2 - 1);
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic             state_q, state_d;
  uart_mode_e       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [NB_W-1:0]  num_bits_q, num_bits_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;

  logic [DIV_W-1:0] div_in;
  logic [NB_W-1:0]  nb_in;
  logic [NB_W-1:0]  last_idx;
  logic [OS_W-1:0]  strobe_pos;
  logic             done_raw;
  logic             start_ok;

  uart_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (i_clear),
    .i_ena     (i_ena),
    .i_run     (state_q),
    .i_divisor (div_q),
    .o_tick    (o_tick)
  );

  always_comb begin
    div_in = (i_divisor == '0) ? DIV_W'(1) : i_divisor;
    if (i_num_bits == '0)                    nb_in = NB_W'(1);
    else if (i_num_bits > NB_W'(MAX_BITS))   nb_in = NB_W'(MAX_BITS);
    else                                     nb_in = i_num_bits;

    last_idx     = num_bits_q - NB_W'(1);
    strobe_pos   = (mode_q == RX_MODE) ? OS_MID : OS_LAST;
    o_busy       = (state_q == RUN);
    o_bit_idx    = bit_idx_q;
    o_bit_strobe = o_tick & (os_cnt_q == strobe_pos);
    done_raw     = o_bit_strobe & ({1'b0, bit_idx_q} == last_idx);
    o_done       = done_raw & ~i_clear;
    // A restart is legal in the done cycle so frames can run back to back.
    start_ok     = i_start & ~i_clear & (~o_busy | done_raw);

    state_d    = state_q;
    mode_d     = mode_q;
    div_d      = div_q;
    num_bits_d = num_bits_q;
    os_cnt_d   = os_cnt_q;
    bit_idx_d  = bit_idx_q;

    if (i_clear) begin
      state_d   = IDLE;
      os_cnt_d  = '0;
      bit_idx_d = '0;
    end else if (start_ok) begin
      state_d    = RUN;
      mode_d     = uart_mode_e'(i_mode);
      div_d      = div_in;
      num_bits_d = nb_in;
      os_cnt_d   = '0;
      bit_idx_d  = '0;
    end else if (done_raw) begin
      state_d   = IDLE;
      os_cnt_d  = '0;
      bit_idx_d = '0;
    end else if (o_tick) begin
      if (os_cnt_q == OS_LAST) begin
        os_cnt_d  = '0;
        bit_idx_d = bit_idx_q + BIT_W'(1);
      end else begin
        os_cnt_d  = os_cnt_q + OS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      mode_q     <= TX_MODE;
      div_q      <= '0;
      num_bits_q <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      num_bits_q <= num_bits_d;
      os_cnt_q   <= os_cnt_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

endmodule

// File: tb/tb_uart_bit_timer.sv
// Directed bench for uart_bit_timer: each run logs ticks, strobes and done pulses per cycle
// (cycle 0 = the i_start cycle) and the results are compared with hand-computed event times.
module tb_uart_bit_timer;

  logic       clk;
  logic       rst;
  logic       i_clear;
  logic       i_ena;
  logic       i_start;
  logic       i_mode;
  logic [15:0] i_divisor;
  logic [4:0] i_num_bits;
  logic       o_busy;
  logic       o_tick;
  logic       o_bit_strobe;
  logic [3:0] o_bit_idx;
  logic       o_done;

  uart_bit_timer dut (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (i_clear),
    .i_ena        (i_ena),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_divisor    (i_divisor),
    .i_num_bits   (i_num_bits),
    .o_busy       (o_busy),
    .o_tick       (o_tick),
    .o_bit_strobe (o_bit_strobe),
    .o_bit_idx    (o_bit_idx),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int strb_cyc[$];
  int strb_idx[$];
  int done_cyc[$];
  int tick_cnt;
  int first_tick;
  int rst_snap;
  bit busy_log[1024];

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sc(input int k);
    return (strb_cyc.size() > k) ? strb_cyc[k] : -1;
  endfunction

  function automatic int si(input int k);
    return (strb_idx.size() > k) ? strb_idx[k] : -1;
  endfunction

  function automatic int dc(input int k);
    return (done_cyc.size() > k) ? done_cyc[k] : -1;
  endfunction

  // Entered just after a rising edge; cycle c's inputs are applied here and outputs sampled at the falling edge.
  task automatic run(input int md, input int dv, input int nb, input int ncyc,
                     input int ena_a, input int ena_b, input int clr_at,
                     input int st2_at, input int md2, input int dv2, input int nb2,
                     input int rst_at);
    strb_cyc.delete();
    strb_idx.delete();
    done_cyc.delete();
    tick_cnt   = 0;
    first_tick = -1;
    rst_snap   = -1;
    for (int c = 0; c < ncyc; c++) begin
      i_start    = (c == 0) || (c == st2_at);
      i_mode     = (c == 0) ? md[0] : md2[0];
      i_divisor  = (c == 0) ? dv[15:0] : dv2[15:0];
      i_num_bits = (c == 0) ? nb[4:0] : nb2[4:0];
      i_ena      = !(c >= ena_a && c <= ena_b);
      i_clear    = (c == clr_at);
      rst        = (c != rst_at);
      @(negedge clk);
      if (c < 1024) busy_log[c] = o_busy;
      if (o_tick) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = c;
      end
      if (o_bit_strobe) begin
        strb_cyc.push_back(c);
        strb_idx.push_back(int'(o_bit_idx));
      end
      if (o_done) done_cyc.push_back(c);
      if (c == rst_at) rst_snap = int'({o_busy, o_tick, o_bit_strobe, o_done, o_bit_idx});
      @(posedge clk);
      #1;
    end
    i_start = 1'b0;
    i_clear = 1'b0;
    i_ena   = 1'b1;
    rst     = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst        = 1'b0;
    i_clear    = 1'b0;
    i_ena      = 1'b1;
    i_start    = 1'b0;
    i_mode     = 1'b0;
    i_divisor  = 16'd3;
    i_num_bits = 5'd10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(o_busy), 0);
    check("rst_tick", int'(o_tick), 0);
    check("rst_strobe", int'(o_bit_strobe), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_idx", int'(o_bit_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // TX, D=3, 10 bits
    run(0, 3, 10, 490, -1, -1, -1, -1, 0, 0, 0, -1);
    check("tx_busy_c0", int'(busy_log[0]), 0);
    check("tx_busy_c1", int'(busy_log[1]), 1);
    check("tx_first_tick", first_tick, 3);
    check("tx_tick_cnt", tick_cnt, 160);
    check("tx_strobe_cnt", strb_cyc.size(), 10);
    check("tx_strobe0", sc(0), 48);
    check("tx_strobe3", sc(3), 192);
    check("tx_idx3", si(3), 3);
    check("tx_strobe9", sc(9), 480);
    check("tx_idx9", si(9), 9);
    check("tx_done_cnt", done_cyc.size(), 1);
    check("tx_done", dc(0), 480);
    check("tx_busy_c480", int'(busy_log[480]), 1);
    check("tx_busy_c481", int'(busy_log[481]), 0);

    // RX, D=3, 10 bits
    run(1, 3, 10, 470, -1, -1, -1, -1, 0, 0, 0, -1);
    check("rx_strobe_cnt", strb_cyc.size(), 10);
    check("rx_strobe0", sc(0), 24);
    check("rx_idx0", si(0), 0);
    check("rx_strobe9", sc(9), 456);
    check("rx_idx9", si(9), 9);
    check("rx_done", dc(0), 456);
    check("rx_busy_c457", int'(busy_log[457]), 0);

    // Divisor 0 -> 1, single-bit frame
    run(0, 0, 1, 30, -1, -1, -1, -1, 0, 0, 0, -1);
    check("d0_first_tick", first_tick, 1);
    check("d0_tick_cnt", tick_cnt, 16);
    check("d0_strobe_cnt", strb_cyc.size(), 1);
    check("d0_strobe", sc(0), 16);
    check("d0_done", dc(0), 16);
    check("d0_busy_c17", int'(busy_log[17]), 0);

    // num_bits 15 clamps to 12
    run(0, 0, 15, 220, -1, -1, -1, -1, 0, 0, 0, -1);
    check("clamp_strobe_cnt", strb_cyc.size(), 12);
    check("clamp_last_idx", si(11), 11);
    check("clamp_done", dc(0), 192);

    // i_ena low for cycles 10..19, ignored start at 200
    run(0, 3, 10, 500, 10, 19, -1, 200, 1, 1, 1, -1);
    check("ena_first_tick", first_tick, 3);
    check("ena_strobe0", sc(0), 58);
    check("ena_strobe_cnt", strb_cyc.size(), 10);
    check("ena_done_cnt", done_cyc.size(), 1);
    check("ena_done", dc(0), 490);
    check("ena_busy_c491", int'(busy_log[491]), 0);

    // i_clear at cycle 100
    run(0, 3, 10, 200, -1, -1, 100, -1, 0, 0, 0, -1);
    check("clr_strobe_cnt", strb_cyc.size(), 2);
    check("clr_strobe1", sc(1), 96);
    check("clr_done_cnt", done_cyc.size(), 0);
    check("clr_busy_c100", int'(busy_log[100]), 1);
    check("clr_busy_c101", int'(busy_log[101]), 0);

    // async reset at cycle 300 of a frame
    run(0, 3, 10, 320, -1, -1, -1, -1, 0, 0, 0, 300);
    check("arst_busy_c299", int'(busy_log[299]), 1);
    check("arst_outputs", rst_snap, 0);
    check("arst_strobe_cnt", strb_cyc.size(), 6);
    check("arst_done_cnt", done_cyc.size(), 0);
    check("arst_busy_c305", int'(busy_log[305]), 0);

    // back-to-back: RX, D=1 restarted in the done cycle
    run(0, 3, 10, 650, -1, -1, -1, 480, 1, 1, 10, -1);
    check("b2b_done0", dc(0), 480);
    check("b2b_busy_c481", int'(busy_log[481]), 1);
    check("b2b_busy_c500", int'(busy_log[500]), 1);
    check("b2b_strobe10", sc(10), 488);
    check("b2b_idx10", si(10), 0);
    check("b2b_done_cnt", done_cyc.size(), 2);
    check("b2b_done1", dc(1), 632);
    check("b2b_busy_c633", int'(busy_log[633]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
